// File: rtl/alarm_pkg.sv
// Shared state encoding and default timing constants for the alarm responder.
package alarm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_SIREN   = 2'd2,
        ST_HOLD    = 2'd3
    } alarm_state_t;

    localparam int ENTRY_DELAY_DEF = 4;
    localparam int SIREN_MAX_DEF   = 16;
    localparam int CNT_W_DEF       = 8;

endpackage

// File: rtl/alarm_responder_edge_detect_rise.sv
// Registered rising-edge detector; the reset value of the delayed copy suppresses
// a false edge when the input is already high as reset releases.
module edge_detect_rise #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk_2,
    input  logic reset,
    input  logic sig,
    output logic rise
);

    logic sig_q;
    logic sig_d;

    always_comb begin
        sig_d = sig;
    end

    always_ff @(posedge clk_2) begin
        if (!reset) begin
            sig_q <= RST_VAL;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign rise = sig & ~sig_q;

endmodule

// File: rtl/alarm_responder.sv
// Alarm sequencing FSM: entry delay, bounded siren, acknowledge/hold-off.
// Build option ALARM_LATCH_EN: when defined, the siren ignores req dropping.
//
// state   | meaning
// IDLE    | disarmed or no alarm request; timer held at 0
// PENDING | entry delay running; ack cancels back to IDLE
// SIREN   | siren on; ends on ack, timer expiry, disarm (or req low if non-latching)
// HOLD    | siren silenced; waits for req to clear before rearming
module alarm_responder
    import alarm_pkg::*;
#(
    parameter int ENTRY_DELAY = ENTRY_DELAY_DEF,
    parameter int SIREN_MAX   = SIREN_MAX_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic             clk_2,
    input  logic             reset,
    input  logic             req,
    input  logic             ack,
    input  logic             armed,
    output logic             siren,
    output logic             pending,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] timer_o
);

    localparam logic [CNT_W-1:0] ENTRY_LOAD = CNT_W'(ENTRY_DELAY - 1);
    localparam logic [CNT_W-1:0] SIREN_LOAD = CNT_W'(SIREN_MAX - 1);
    localparam logic [CNT_W-1:0] TIMER_ONE  = CNT_W'(1);

    alarm_state_t     state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic             ack_edge;

    edge_detect_rise #(
        .RST_VAL (1'b1)
    ) u_ack_edge (
        .clk_2 (clk_2),
        .reset (reset),
        .sig   (ack),
        .rise  (ack_edge)
    );

    always_ff @(posedge clk_2) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = '0;
        case (state_q)
            ST_IDLE: begin
                if (armed && req) begin
                    state_d = ST_PENDING;
                    timer_d = ENTRY_LOAD;
                end
            end
            ST_PENDING: begin
                // req dropping does not cancel: the entry delay is committed
                if (!armed || ack_edge) begin
                    state_d = ST_IDLE;
                end else if (timer_q == '0) begin
                    state_d = ST_SIREN;
                    timer_d = SIREN_LOAD;
                end else begin
                    timer_d = timer_q - TIMER_ONE;
                end
            end
            ST_SIREN: begin
                if (!armed) begin
                    state_d = ST_IDLE;
                end else if (ack_edge || timer_q == '0) begin
                    state_d = ST_HOLD;
`ifdef ALARM_LATCH_EN
                end else begin
                    timer_d = timer_q - TIMER_ONE;
                end
`else
                end else if (!req) begin
                    state_d = ST_IDLE;
                end else begin
                    timer_d = timer_q - TIMER_ONE;
                end
`endif
            end
            ST_HOLD: begin
                if (!armed || !req) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign siren   = (state_q == ST_SIREN);
    assign pending = (state_q == ST_PENDING);
    assign state_o = state_q;
    assign timer_o = timer_q;

endmodule

// File: tb/tb_alarm_responder.sv
// Self-checking bench for alarm_responder: directed scenarios plus randomized
// traffic against a phase/elapsed-time reference model.
module tb_alarm_responder;

    localparam int ED = 4;
    localparam int SM = 16;
    localparam int CW = 8;
`ifdef ALARM_LATCH_EN
    localparam bit LATCH = 1'b1;
`else
    localparam bit LATCH = 1'b0;
`endif

    logic          clk_2 = 1'b0;
    logic          reset;
    logic          req;
    logic          ack;
    logic          armed;
    logic          siren;
    logic          pending;
    logic [1:0]    state_o;
    logic [CW-1:0] timer_o;

    int n_checks = 0;
    int n_pass   = 0;

    // reference model: phase 0 idle, 1 entry, 2 sounding, 3 hold-off; m_el counts cycles spent in the phase
    int m_phase = 0;
    int m_el    = 0;
    bit m_prev_ack = 1'b1;

    alarm_responder #(
        .ENTRY_DELAY (ED),
        .SIREN_MAX   (SM),
        .CNT_W       (CW)
    ) dut (
        .clk_2   (clk_2),
        .reset   (reset),
        .req     (req),
        .ack     (ack),
        .armed   (armed),
        .siren   (siren),
        .pending (pending),
        .state_o (state_o),
        .timer_o (timer_o)
    );

    always #5 clk_2 = ~clk_2;

    task automatic model_edge();
        bit pressed;
        pressed = ack && !m_prev_ack;
        if (!reset) begin
            m_phase = 0; m_el = 0; m_prev_ack = 1'b1;
            return;
        end
        m_prev_ack = ack;
        case (m_phase)
            0: if (armed && req) begin m_phase = 1; m_el = 0; end
            1: begin
                if (!armed || pressed) m_phase = 0;
                else if (m_el == ED - 1) begin m_phase = 2; m_el = 0; end
                else m_el++;
            end
            2: begin
                if (!armed) m_phase = 0;
                else if (pressed || m_el == SM - 1) m_phase = 3;
                else if (!LATCH && !req) m_phase = 0;
                else m_el++;
            end
            default: if (!armed || !req) m_phase = 0;
        endcase
    endtask

    function automatic logic [CW+3:0] model_vec();
        int t;
        t = (m_phase == 1) ? (ED - 1 - m_el) : (m_phase == 2) ? (SM - 1 - m_el) : 0;
        return {m_phase[1:0], t[CW-1:0], (m_phase == 2), (m_phase == 1)};
    endfunction

    task automatic step();
        @(posedge clk_2);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; ack = 1'b1; armed = 1'b1; req = 1'b1;
        repeat (3) step();
        n_checks++;
        if ({state_o, timer_o, siren, pending} !== {2'd0, 8'd0, 1'b0, 1'b0})
            $display("FAIL reset_hold: got st=%0d t=%0d s=%b p=%b, want all 0", state_o, timer_o, siren, pending);
        else n_pass++;
        reset = 1'b1; armed = 1'b0; req = 1'b0;
        step();
        armed = 1'b1;
        step();
        n_checks++;
        if ({state_o, timer_o, siren, pending} !== {2'd0, 8'd0, 1'b0, 1'b0})
            $display("FAIL reset_release_ack_high: got st=%0d t=%0d s=%b p=%b, want all 0", state_o, timer_o, siren, pending);
        else n_pass++;
    endtask

    task automatic test_nominal();
        ack = 1'b0; armed = 1'b1; req = 1'b1;
        for (int i = 0; i < ED; i++) begin
            step();
            n_checks++;
            if ({pending, siren, timer_o} !== {1'b1, 1'b0, 8'(ED - 1 - i)})
                $display("FAIL nominal_pending[%0d]: got p=%b s=%b t=%0d, want p=1 s=0 t=%0d", i, pending, siren, timer_o, ED - 1 - i);
            else n_pass++;
        end
        for (int i = 0; i < SM; i++) begin
            step();
            n_checks++;
            if ({siren, state_o, timer_o} !== {1'b1, 2'd2, 8'(SM - 1 - i)})
                $display("FAIL nominal_siren[%0d]: got s=%b st=%0d t=%0d, want s=1 st=2 t=%0d", i, siren, state_o, timer_o, SM - 1 - i);
            else n_pass++;
        end
        repeat (3) begin
            step();
            n_checks++;
            if ({state_o, siren, timer_o} !== {2'd3, 1'b0, 8'd0})
                $display("FAIL nominal_hold: got st=%0d s=%b t=%0d, want st=3 s=0 t=0", state_o, siren, timer_o);
            else n_pass++;
        end
        req = 1'b0;
        step();
        n_checks++;
        if (state_o !== 2'd0)
            $display("FAIL nominal_release: got st=%0d, want 0", state_o);
        else n_pass++;
    endtask

    task automatic test_ack_pending();
        bit saw_siren = 1'b0;
        ack = 1'b0; armed = 1'b1; req = 1'b1;
        step(); step();
        n_checks++;
        if (timer_o !== 8'd2)
            $display("FAIL ack_pending_timer: got t=%0d, want 2", timer_o);
        else n_pass++;
        ack = 1'b1;
        step();
        n_checks++;
        if (state_o !== 2'd0)
            $display("FAIL ack_pending_cancel: got st=%0d, want 0", state_o);
        else n_pass++;
        req = 1'b0;
        repeat (8) begin
            step();
            if (siren) saw_siren = 1'b1;
        end
        n_checks++;
        if (saw_siren !== 1'b0)
            $display("FAIL ack_pending_no_siren: got siren seen=%b, want 0", saw_siren);
        else n_pass++;
        ack = 1'b0;
        step();
    endtask

    task automatic test_ack_at_expiry();
        ack = 1'b0; armed = 1'b1; req = 1'b1;
        repeat (ED + SM) step();
        n_checks++;
        if ({siren, timer_o} !== {1'b1, 8'd0})
            $display("FAIL expiry_setup: got s=%b t=%0d, want s=1 t=0", siren, timer_o);
        else n_pass++;
        ack = 1'b1;
        step();
        n_checks++;
        if ({state_o, siren} !== {2'd3, 1'b0})
            $display("FAIL ack_at_expiry: got st=%0d s=%b, want st=3 s=0", state_o, siren);
        else n_pass++;
        ack = 1'b0; req = 1'b0;
        step();
        n_checks++;
        if (state_o !== 2'd0)
            $display("FAIL expiry_release: got st=%0d, want 0", state_o);
        else n_pass++;
    endtask

    task automatic test_req_drop_siren();
        ack = 1'b0; armed = 1'b1; req = 1'b1;
        repeat (ED + 3) step();
        req = 1'b0;
        step();
        n_checks++;
        if (state_o !== (LATCH ? 2'd2 : 2'd0))
            $display("FAIL req_drop_siren: got st=%0d, want %0d", state_o, LATCH ? 2 : 0);
        else n_pass++;
        repeat (SM) begin
            step();
            n_checks++;
            if ({state_o, timer_o, siren, pending} !== model_vec())
                $display("FAIL req_drop_track: got %h, want %h", {state_o, timer_o, siren, pending}, model_vec());
            else n_pass++;
        end
        n_checks++;
        if (state_o !== 2'd0)
            $display("FAIL req_drop_final: got st=%0d, want 0", state_o);
        else n_pass++;
    endtask

    task automatic test_disarm_and_reset();
        ack = 1'b0; armed = 1'b1; req = 1'b1;
        repeat (ED + 2) step();
        armed = 1'b0;
        step();
        n_checks++;
        if ({state_o, timer_o, siren} !== {2'd0, 8'd0, 1'b0})
            $display("FAIL disarm_siren: got st=%0d t=%0d s=%b, want 0 0 0", state_o, timer_o, siren);
        else n_pass++;
        armed = 1'b1;
        repeat (ED + 1) step();
        ack = 1'b1;
        step();
        ack = 1'b0;
        step();
        n_checks++;
        if (state_o !== 2'd3)
            $display("FAIL disarm_hold_setup: got st=%0d, want 3", state_o);
        else n_pass++;
        armed = 1'b0;
        step();
        n_checks++;
        if (state_o !== 2'd0)
            $display("FAIL disarm_hold: got st=%0d, want 0", state_o);
        else n_pass++;
        armed = 1'b1;
        step(); step();
        reset = 1'b0;
        step();
        n_checks++;
        if ({state_o, timer_o, pending} !== {2'd0, 8'd0, 1'b0})
            $display("FAIL reset_mid_pending: got st=%0d t=%0d p=%b, want 0 0 0", state_o, timer_o, pending);
        else n_pass++;
        reset = 1'b1; req = 1'b0;
        step();
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 199) != 0);
            armed = ($urandom_range(0, 39) != 0);
            req   = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 5) == 0) ack = ~ack;
            step();
            n_checks++;
            if ({state_o, timer_o, siren, pending} !== model_vec())
                $display("FAIL random[%0d]: got st=%0d t=%0d s=%b p=%b, want %h", i, state_o, timer_o, siren, pending, model_vec());
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_ack_pending();
        test_ack_at_expiry();
        test_req_drop_siren();
        test_disarm_and_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alarm_responder.md
# alarm_responder

Sequential response side of the door/clock/switch alarm: accepts the alarm request produced by the combinational detector and sequences it through an entry delay, a bounded siren period, and an acknowledge/hold-off phase. Sits between the detector logic (driven from `SWI`) and the board outputs (`LED`, `SEG`, LCD debug signals). All outputs are registered and all timing is counted in `clk_2` cycles.

## Interface
- `ENTRY_DELAY`, default 4: cycles spent in PENDING before the siren sounds; legal range 1..2^CNT_W.
- `SIREN_MAX`, default 16: maximum cycles the siren stays on without an acknowledge; legal range 1..2^CNT_W.
- `CNT_W`, default 8: width of the countdown timer.

- `clk_2` input 1: sole clock; every register updates on its rising edge.
- `reset` input 1: synchronous, active-low reset, sampled on the `clk_2` rising edge.
- `req` input 1: alarm condition from the detector (level).
- `ack` input 1: user acknowledge (level); only its rising edge acts.
- `armed` input 1: system armed (level); low forces IDLE.
- `siren` output 1: high in SIREN.
- `pending` output 1: high in PENDING.
- `state_o` output 2: current state code.
- `timer_o` output CNT_W: current countdown value, for LCD display.

## Operation
- States: IDLE=0, PENDING=1, SIREN=2, HOLD=3.
- Ack edge: `ack_edge = ack & ~ack_q`, where `ack_q` is `ack` delayed one cycle. `ack_q` resets to 1, so an `ack` held high through reset release does not produce an edge.
- Priority in every non-IDLE state, highest first: `!armed` → IDLE, then `ack_edge`, then timer expiry, then `req` rules.
- IDLE: if `armed & req`, go to PENDING and load timer = ENTRY_DELAY-1. Otherwise stay in IDLE with timer = 0.
- PENDING:
  - `ack_edge` → IDLE (user disarm within the entry window).
  - timer==0 → SIREN and load timer = SIREN_MAX-1.
  - Otherwise decrement the timer.
  - `req` falling does not cancel PENDING; the entry delay is committed.
- SIREN:
  - `ack_edge` → HOLD.
  - timer==0 → HOLD (auto-silence).
  - Otherwise decrement the timer.
  - `req` low: behaviour set by ALARM_LATCH_EN (see Configuration).
- HOLD: siren off, timer = 0. Go to IDLE when `req`==0; stay while `req`==1, so there is no retrigger until the condition clears.
- Timer arithmetic: unsigned CNT_W bits. The timer only decrements when nonzero, so it never wraps.
- Outputs are decoded from the registered state: `siren` = (state==SIREN), `pending` = (state==PENDING).

## Timing
- Reset (`reset`==0 at an edge): state = IDLE, timer = 0, `ack_q` = 1, `siren` = 0, `pending` = 0, `state_o` = 0, `timer_o` = 0. Reset overrides all other inputs, including mid-PENDING or mid-SIREN.
- Latency: `armed & req` sampled at edge k gives `pending`=1 after edge k.
- PENDING lasts exactly ENTRY_DELAY cycles; `siren`=1 after edge k+ENTRY_DELAY.
- SIREN lasts at most SIREN_MAX cycles.
- `ack` rising between edges j-1 and j gives its state effect after edge j (one-cycle latency).
- Simultaneous timer==0 and `ack_edge`: the ack wins. PENDING → IDLE; SIREN → HOLD (same state either way).
- Simultaneous `!armed` with anything: IDLE.

## Configuration
- `ALARM_LATCH_EN` defined: SIREN ignores `req`; the siren latches until `ack_edge`, timer expiry, or `!armed`.
- `ALARM_LATCH_EN` undefined: in SIREN, `req`==0 → IDLE on the next edge (non-latching alarm). This rule has lower priority than `!armed`, `ack_edge`, and timer expiry.

## Structure
- Package `alarm_pkg`: `alarm_state_t` enum (IDLE/PENDING/SIREN/HOLD with the fixed 2-bit codes above) and default constants for ENTRY_DELAY and SIREN_MAX.
- Sub-module `edge_detect_rise`: the registered rising-edge detector for `ack`, with a reset value parameter set to 1. It must use the same `clk_2` and synchronous active-low reset.
- FSM and timer live in `alarm_responder`.

## Test plan
Default parameters (ENTRY_DELAY=4, SIREN_MAX=16) unless stated.
- Reset with `ack`=1, then release with `ack` held high → state stays 0, no spurious edge; `siren`=0, `pending`=0, `timer_o`=0.
- `armed`=1, `req`=1 from edge 0 → `pending`=1 for edges 1..4 with `timer_o` 3,2,1,0; `siren`=1 from edge 5 with `timer_o`=15; `siren` drops at edge 21; state=3 while `req`=1; state=0 one edge after `req`=0.
- `ack` pulse during PENDING (`timer_o`=2) → state=0 next edge, `siren` never asserts.
- In SIREN, `ack` rises in the cycle where `timer_o`=0 → state=3 (HOLD), `siren`=0.
- In SIREN, drop `req` → with ALARM_LATCH_EN, `siren` stays 1 until timer expiry; without it, state=0 next edge.
- `armed`=0 during SIREN and during HOLD; separately, `reset`=0 mid-PENDING → state=0, `timer_o`=0 after one edge.
